// File: rtl/fib_gen_pkg.sv
// Shared types and helpers for the Fibonacci generator family.
package fib_gen_pkg;

    // Generator control state; 2 bits leaves room for sibling generators.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
    } state_t;

    // Widest data field carried by the shared beat record.
    localparam int BEAT_W = 64;

    // One handshake beat as seen by a consumer of any generator.
    typedef struct packed {
        logic              done;
        logic [BEAT_W-1:0] data0;
        logic [BEAT_W-1:0] data1;
    } beat_t;

    // Euclidean residue: always in 0..divisor-1, even for negative values.
    function automatic longint euclid_mod(input longint value, input longint divisor);
        return ((value % divisor) + divisor) % divisor;
    endfunction

endpackage

// File: rtl/fib_filter_gen_if.sv
// Start/ready/valid/done generator handshake shared by the generator fabric.
// Handshake: a beat (data or done) is presented while __valid=1 and is
// consumed on the rising edge where __ready=1; the generator holds the beat
// unchanged until then. __start restarts the generator at any time and
// discards whatever beat is pending.
interface fib_filter_gen_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) ();
    import fib_gen_pkg::*;

    logic                    __start;
    logic signed [WIDTH-1:0] n;
    logic signed [WIDTH-1:0] residue;
    logic [CNT_W-1:0]        max_count;
    logic                    __ready;
    logic                    __valid;
    logic                    __done;
    logic signed [WIDTH-1:0] __output_0;
    logic signed [WIDTH-1:0] __output_1;
    logic                    __overflow;
    state_t                  state;

    // Caller side: starts the generator and consumes its beats.
    modport master (
        output __start, n, residue, max_count, __ready,
        input  __valid, __done, __output_0, __output_1, __overflow, state
    );

    // Generator side.
    modport slave (
        input  __start, n, residue, max_count, __ready,
        output __valid, __done, __output_0, __output_1, __overflow, state
    );
endinterface

// File: rtl/fib_residue_match.sv
// Combinational residue filter: flags terms whose Euclidean residue modulo
// DIVISOR equals the requested residue. A residue outside 0..DIVISOR-1 can
// never equal a Euclidean residue, so it never matches. DIVISOR must be >= 1.
module fib_residue_match
    import fib_gen_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIVISOR = 2
) (
    input  logic signed [WIDTH-1:0] term,
    input  logic signed [WIDTH-1:0] residue,
    output logic                    match
);
    longint term_x;
    longint res_x;

    assign term_x = longint'(term);
    assign res_x  = longint'(residue);
    assign match  = (euclid_mod(term_x, longint'(DIVISOR)) == res_x);
endmodule

// File: rtl/fib_filter_gen.sv
// Streams Fibonacci terms below n whose residue modulo DIVISOR matches a
// runtime residue, with an optional emit limit and overflow-safe ending.
module fib_filter_gen
    import fib_gen_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIVISOR = 2,
    parameter int CNT_W   = 16
) (
    input  logic            __clock,
    input  logic            __reset_n,
    fib_filter_gen_if.slave bus
);
    localparam logic signed [WIDTH-1:0] ONE = 1;

    state_t                  state_q;
    logic signed [WIDTH-1:0] a;
    logic signed [WIDTH-1:0] b;
    logic signed [WIDTH-1:0] idx;
    logic signed [WIDTH-1:0] n_q;
    logic signed [WIDTH-1:0] res_q;
    logic signed [WIDTH-1:0] sum;
    logic signed [WIDTH-1:0] out0_q;
    logic signed [WIDTH-1:0] out1_q;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        max_q;
    logic                    ovf_a;
    logic                    ovf_b;
    logic                    sum_ovf;
    logic                    valid_q;
    logic                    done_q;
    logic                    ovf_q;
    logic                    hit;
    logic                    step;

    fib_residue_match #(
        .WIDTH  (WIDTH),
        .DIVISOR(DIVISOR)
    ) u_match (
        .term   (a),
        .residue(res_q),
        .match  (hit)
    );

    // ovf_b marks b (and everything after it) as no longer a true term;
    // it reaches ovf_a one step later, exactly when the bad value becomes a.
    assign sum     = a + b;
    assign sum_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign step    = (state_q == S_RUN) && (bus.__ready || !valid_q);

    // Generator FSM and datapath: start has priority, then beat consumption,
    // then one RUN step per unstalled cycle.
    always_ff @(posedge __clock or negedge __reset_n) begin
        if (!__reset_n) begin
            state_q <= S_IDLE;
            a       <= '0;
            b       <= '0;
            idx     <= '0;
            count   <= '0;
            n_q     <= '0;
            res_q   <= '0;
            max_q   <= '0;
            ovf_a   <= 1'b0;
            ovf_b   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
        end else if (bus.__start) begin
            n_q     <= bus.n;
            res_q   <= bus.residue;
            max_q   <= bus.max_count;
            a       <= '0;
            b       <= ONE;
            idx     <= '0;
            count   <= '0;
            ovf_a   <= 1'b0;
            ovf_b   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= S_RUN;
        end else begin
            if (bus.__ready) begin
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end
            if (step) begin
                if (ovf_a) begin
                    valid_q <= 1'b1;
                    done_q  <= 1'b1;
                    ovf_q   <= 1'b1;
                    state_q <= S_IDLE;
                end else if (a >= n_q) begin
                    valid_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end else if ((max_q != '0) && (count == max_q)) begin
                    valid_q <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end else begin
                    if (hit) begin
                        out0_q  <= a;
                        out1_q  <= idx;
                        valid_q <= 1'b1;
                        count   <= count + CNT_W'(1);
                    end
                    a     <= b;
                    b     <= sum;
                    idx   <= idx + ONE;
                    ovf_a <= ovf_b;
                    ovf_b <= ovf_b | sum_ovf;
                end
            end
        end
    end

    assign bus.__valid    = valid_q;
    assign bus.__done     = done_q;
    assign bus.__overflow = ovf_q;
    assign bus.__output_0 = out0_q;
    assign bus.__output_1 = out1_q;
    assign bus.state      = state_q;
endmodule
